mdu_alu_ctrl: RTL
=================

Name: mdu_alu_ctrl

Overview:
- Parametrised successor to the single-cycle ALU control decoder.
- Widens `alu_ctrl` to 4 bits and decodes the full R-type ALU set (xor, nor, sltu, shifts).
- Adds an iterative multiply/divide sequencer that owns the HI/LO registers.
- Sits beside the ALU in the execute stage. The datapath stalls on `stall` while a `mfhi`/`mflo` waits for a multiply or divide still in progress.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be ≥4 and even.
- CTRL_W, 4, `alu_ctrl` width; fixed encoding below, must be ≥4.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- aluop  in  2  main-control ALU op class
- func  in  6  R-type funct field
- a  in  WIDTH  rs operand (dividend / multiplicand / mthi-mtlo source)
- b  in  WIDTH  rt operand (divisor / multiplier)
- start  in  1  instruction valid in execute this cycle
- alu_ctrl  out  CTRL_W  ALU operation select (combinational)
- busy  out  1  multiply/divide in progress
- done  out  1  one-cycle pulse when HI/LO updated by mult/div
- stall  out  1  (aluop==10 and func is mfhi/mflo) and busy
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset: rst=1 at an edge forces state IDLE and clears `busy`, `done`, `hi`, `lo` and all iteration registers. This also applies mid-operation; the aborted result is discarded.
- `alu_ctrl` decode (combinational, no reset):
  - aluop 00 → 0010 ADD; aluop 01 → 0110 SUB; aluop 11 → 0111 SLT.
  - aluop 10, by func:
    - 100000/100001 → 0010; 100010/100011 → 0110
    - 100100 → 0000 AND; 100101 → 0001 OR; 100110 → 0011 XOR; 100111 → 1100 NOR
    - 101010 → 0111 SLT; 101011 → 1111 SLTU
    - 000000 → 1000 SLL; 000010 → 1001 SRL; 000011 → 1010 SRA
    - any other func → 0000.
- MDU commands (aluop==10, start=1, state IDLE or DONE):
  - 011000 mult, 011001 multu, 011010 div, 011011 divu.
  - 010001 mthi: hi←a at the edge, no busy. 010011 mtlo: lo←a at the edge, no busy.
  - `start` in any other state is ignored. The pipeline guarantees it via `stall`/`busy`.
- States: IDLE, MUL, DIV, FIX, DONE.
  - Start edge (cycle 0): latch |a|, |b|, and sign flags (signed ops only); clear count; go to MUL or DIV.
  - MUL: shift-add, one multiplier bit per cycle, WIDTH cycles, 2·WIDTH-bit accumulator.
  - DIV: restoring division, one quotient bit per cycle, WIDTH cycles.
  - After the last iteration → FIX.
  - FIX (one cycle): apply signs.
    - Product negated if sa^sb.
    - Quotient negated if sa^sb; remainder negated if sa.
    - Write hi/lo; → DONE.
  - DONE: done=1 for exactly one cycle. Acts as IDLE for a new start; otherwise → IDLE.
- Latency: start in cycle 0 → busy=1 in cycles 1..WIDTH+1; done=1 with valid hi/lo in cycle WIDTH+2; busy=0 in DONE.
- Arithmetic rules:
  - Magnitudes are WIDTH-bit unsigned, so the most negative value (MIN) is representable.
  - MIN/-1 wraps: lo=MIN, hi=0.
  - Divide by zero (b==0): same latency; hi=a (raw dividend), lo=all ones; no exception.
  - Unsigned ops never negate.
- Hazards:
  - `mfhi`/`mflo` while busy raises `stall`.
  - In the DONE cycle, hi/lo already hold the new result; no stall.
  - `mthi`/`mtlo` while busy is undefined; the pipeline prevents it.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined: in MUL, when the remaining shifted multiplier is zero, the block goes to FIX on the next edge. Multiply latency then drops to (index of highest set bit of |b|)+3, minimum 3 cycles (b==0). Divide is unaffected.
- Undefined: fixed latency WIDTH+2 for all multiply and divide operations.

Decomposition:
- Package `mdu_pkg`:
  - ALU_CTRL_* localparams (4-bit codes).
  - FUNC_* funct constants.
  - ALUOP_* codes.
  - MDU state enum encoding.
- Sub-module `mdu_alu_dec`: pure combinational aluop/func → `alu_ctrl` plus is_mdu/is_mf/is_mt flags.
- Sequencer and HI/LO registers stay in the top module.

Test Plan:
- Decode sweep: aluop=10, func=100111 → alu_ctrl=1100; func=101011 → 1111; func=000011 → 1010; aluop=11 → 0111; unknown func 111111 → 0000.
- multu 0xFFFFFFFF × 0xFFFFFFFF, start at cycle 0 → done at cycle 34, hi=0xFFFFFFFE, lo=0x00000001; busy high cycles 1–33.
- mult −3 × 5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then div −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then div 0x80000000/−1 → lo=0x80000000, hi=0.
- divu 5/0 → hi=5, lo=0xFFFFFFFF at cycle 34. mthi 0x1234 → hi=0x1234 next cycle, busy never set.
- mfhi issued at cycle 10 of a mult → stall=1 through cycle 33, 0 at cycle 34. rst at cycle 20 → next cycle busy=0, hi=lo=0, state IDLE, no done pulse.
- With MDU_EARLY_OUT_EN: multu 7×3 → done at cycle 4, lo=21. multu with b=0 → done at cycle 3, hi=lo=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared ALU control codes, funct/aluop constants and MDU sequencer states
package mdu_pkg;
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_SLT = 2'b11;
  localparam logic [3:0] ALU_CTRL_AND  = 4'b0000;
  localparam logic [3:0] ALU_CTRL_OR   = 4'b0001;
  localparam logic [3:0] ALU_CTRL_ADD  = 4'b0010;
  localparam logic [3:0] ALU_CTRL_XOR  = 4'b0011;
  localparam logic [3:0] ALU_CTRL_SUB  = 4'b0110;
  localparam logic [3:0] ALU_CTRL_SLT  = 4'b0111;
  localparam logic [3:0] ALU_CTRL_SLL  = 4'b1000;
  localparam logic [3:0] ALU_CTRL_SRL  = 4'b1001;
  localparam logic [3:0] ALU_CTRL_SRA  = 4'b1010;
  localparam logic [3:0] ALU_CTRL_NOR  = 4'b1100;
  localparam logic [3:0] ALU_CTRL_SLTU = 4'b1111;
  localparam logic [5:0] FUNC_SLL   = 6'b000000;
  localparam logic [5:0] FUNC_SRL   = 6'b000010;
  localparam logic [5:0] FUNC_SRA   = 6'b000011;
  localparam logic [5:0] FUNC_MFHI  = 6'b010000;
  localparam logic [5:0] FUNC_MTHI  = 6'b010001;
  localparam logic [5:0] FUNC_MFLO  = 6'b010010;
  localparam logic [5:0] FUNC_MTLO  = 6'b010011;
  localparam logic [5:0] FUNC_MULT  = 6'b011000;
  localparam logic [5:0] FUNC_MULTU = 6'b011001;
  localparam logic [5:0] FUNC_DIV   = 6'b011010;
  localparam logic [5:0] FUNC_DIVU  = 6'b011011;
  localparam logic [5:0] FUNC_ADD   = 6'b100000;
  localparam logic [5:0] FUNC_ADDU  = 6'b100001;
  localparam logic [5:0] FUNC_SUB   = 6'b100010;
  localparam logic [5:0] FUNC_SUBU  = 6'b100011;
  localparam logic [5:0] FUNC_AND   = 6'b100100;
  localparam logic [5:0] FUNC_OR    = 6'b100101;
  localparam logic [5:0] FUNC_XOR   = 6'b100110;
  localparam logic [5:0] FUNC_NOR   = 6'b100111;
  localparam logic [5:0] FUNC_SLT   = 6'b101010;
  localparam logic [5:0] FUNC_SLTU  = 6'b101011;
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} mdu_state_e;
endpackage

// File: rtl/mdu_alu_dec.sv
// mdu_alu_dec: combinational aluop/func decode to alu_ctrl plus MDU command flags
// Ports: aluop, func in; alu_ctrl (4-bit code), is_mdu (mult/div), is_mf (mfhi/mflo), is_mt (mthi/mtlo) out.
module mdu_alu_dec
  import mdu_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] func,
  output logic [3:0] alu_ctrl,
  output logic       is_mdu,
  output logic       is_mf,
  output logic       is_mt
);
  logic [3:0] rcode;
  logic       is_r;
  always_comb begin
    case (func)
      FUNC_ADD, FUNC_ADDU: rcode = ALU_CTRL_ADD;
      FUNC_SUB, FUNC_SUBU: rcode = ALU_CTRL_SUB;
      FUNC_AND:            rcode = ALU_CTRL_AND;
      FUNC_OR:             rcode = ALU_CTRL_OR;
      FUNC_XOR:            rcode = ALU_CTRL_XOR;
      FUNC_NOR:            rcode = ALU_CTRL_NOR;
      FUNC_SLT:            rcode = ALU_CTRL_SLT;
      FUNC_SLTU:           rcode = ALU_CTRL_SLTU;
      FUNC_SLL:            rcode = ALU_CTRL_SLL;
      FUNC_SRL:            rcode = ALU_CTRL_SRL;
      FUNC_SRA:            rcode = ALU_CTRL_SRA;
      default:             rcode = 4'b0000;
    endcase
  end
  assign is_r     = aluop == ALUOP_R;
  assign alu_ctrl = aluop == ALUOP_ADD ? ALU_CTRL_ADD :
                    aluop == ALUOP_SUB ? ALU_CTRL_SUB :
                    aluop == ALUOP_SLT ? ALU_CTRL_SLT : rcode;
  assign is_mdu   = is_r && func[5:2] == FUNC_MULT[5:2];
  assign is_mf    = is_r && (func == FUNC_MFHI || func == FUNC_MFLO);
  assign is_mt    = is_r && (func == FUNC_MTHI || func == FUNC_MTLO);
endmodule

// File: rtl/mdu_alu_ctrl.sv
// mdu_alu_ctrl: ALU control decode plus iterative multiply/divide sequencer owning HI/LO
// Ports: clk, rst (sync, active high), aluop, func, a, b, start in;
//        alu_ctrl, busy, done, stall, hi, lo out.
// Macro MDU_EARLY_OUT_EN: multiply finishes as soon as the remaining multiplier bits are zero.
module mdu_alu_ctrl
  import mdu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        aluop,
  input  logic [5:0]        func,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              start,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              busy,
  output logic              done,
  output logic              stall,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo
);
  localparam int CW = $clog2(WIDTH);
  mdu_state_e state, state_d;
  logic [3:0] code;
  logic is_mdu, is_mf, is_mt, sgn, a_neg, b_neg, idle_ok, go, last, mul_end, ge, sa, sb, op_div;
  logic [WIDTH-1:0] a_mag, b_mag, mb, rem_sub, raw_a;
  logic [WIDTH:0] rem_sh;
  logic [2*WIDTH-1:0] acc, mcand, prod;
  logic [CW-1:0] cnt;
  mdu_alu_dec u_dec (
    .aluop(aluop), .func(func), .alu_ctrl(code), .is_mdu(is_mdu), .is_mf(is_mf), .is_mt(is_mt)
  );
  assign alu_ctrl = CTRL_W'(code);
  // Even funct codes (mult, div) are the signed variants.
  assign sgn     = ~func[0];
  assign a_neg   = sgn & a[WIDTH-1];
  assign b_neg   = sgn & b[WIDTH-1];
  assign a_mag   = a_neg ? -a : a;
  assign b_mag   = b_neg ? -b : b;
  assign idle_ok = state == S_IDLE || state == S_DONE;
  assign go      = start && idle_ok && is_mdu;
  assign last    = cnt == CW'(WIDTH - 1);
`ifdef MDU_EARLY_OUT_EN
  assign mul_end = last || (mb >> 1) == '0;
`else
  assign mul_end = last;
`endif
  // Division keeps {remainder, dividend/quotient} in acc and shifts one bit per cycle.
  assign rem_sh  = acc[2*WIDTH-1:WIDTH-1];
  assign ge      = rem_sh >= {1'b0, mb};
  assign rem_sub = WIDTH'(rem_sh - {1'b0, mb});
  assign prod    = (sa ^ sb) ? -acc : acc;
  assign raw_a   = sa ? -mcand[WIDTH-1:0] : mcand[WIDTH-1:0];
  assign busy    = state == S_MUL || state == S_DIV || state == S_FIX;
  assign done    = state == S_DONE;
  assign stall   = is_mf && busy;
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE, S_DONE: state_d = go ? (func[1] ? S_DIV : S_MUL) : S_IDLE;
      S_MUL:          state_d = mul_end ? S_FIX : S_MUL;
      S_DIV:          state_d = last ? S_FIX : S_DIV;
      S_FIX:          state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      hi     <= '0;
      lo     <= '0;
      acc    <= '0;
      mcand  <= '0;
      mb     <= '0;
      cnt    <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      op_div <= 1'b0;
    end else begin
      state <= state_d;
      if (go) begin
        sa     <= a_neg;
        sb     <= b_neg;
        mb     <= b_mag;
        mcand  <= {{WIDTH{1'b0}}, a_mag};
        acc    <= func[1] ? {{WIDTH{1'b0}}, a_mag} : '0;
        cnt    <= '0;
        op_div <= func[1];
      end else if (start && idle_ok && is_mt) begin
        if (func[1]) lo <= a;
        else hi <= a;
      end else begin
        case (state)
          S_MUL: begin
            acc   <= acc + (mb[0] ? mcand : '0);
            mcand <= mcand << 1;
            mb    <= mb >> 1;
            cnt   <= cnt + 1'b1;
          end
          S_DIV: begin
            acc <= {ge ? rem_sub : rem_sh[WIDTH-1:0], acc[WIDTH-2:0], ge};
            cnt <= cnt + 1'b1;
          end
          S_FIX: begin
            if (!op_div) {hi, lo} <= prod;
            else if (mb == '0) begin
              hi <= raw_a;
              lo <= '1;
            end else begin
              lo <= (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
              hi <= sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
